// File: rtl/prbs_test_ctrl.sv
// PRBS test-burst controller: preamble, PRBS payload, done pulse, abort and optional error injection.
// Optional single-bit error injection is compiled in when PRBS_ERR_INJ_EN is defined.
module prbs_test_ctrl #(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [63:0] PREAMBLE_WORD = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter logic [63:0] IDLE_WORD     = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] frame_count,
    input  logic        inject_err,
    input  logic [63:0] prbs_in,
    output logic        gen_en,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic [31:0] words_sent,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] frame_len;
    logic [7:0]  pre_cnt;
    logic [63:0] payload;
    logic        start_ok;
    logic        run_active;
    logic        pre_last;
    logic        run_last;
    logic        enter_idle;

    assign start_ok   = (state == IDLE) && start && !abort;
    // An aborted cycle is dead: nothing is consumed, counted or transmitted.
    assign run_active = (state == RUN) && !abort;
    assign pre_last   = (pre_cnt == 8'(PREAMBLE_LEN - 1));
    assign run_last   = (words_sent == frame_len - 32'd1);
    assign enter_idle = (state != IDLE) && (next_state == IDLE);

    assign gen_en = run_active;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE) && !abort;

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = (frame_count == 32'd0) ? DONE : PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (pre_last) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_len  <= '0;
            pre_cnt    <= '0;
            words_sent <= '0;
        end else begin
            state   <= next_state;
            pre_cnt <= (state == PREAMBLE) ? pre_cnt + 8'd1 : 8'd0;
            if (start_ok) begin
                frame_len  <= frame_count;
                words_sent <= '0;
            end else if (run_active) begin
                words_sent <= words_sent + 32'd1;
            end
        end
    end

    // Output word lags the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= IDLE_WORD;
            tx_valid <= 1'b0;
        end else if ((state == PREAMBLE) && !abort) begin
            tx_data  <= PREAMBLE_WORD;
            tx_valid <= 1'b1;
        end else if (run_active) begin
            tx_data  <= payload;
            tx_valid <= 1'b1;
        end else begin
            tx_data  <= IDLE_WORD;
            tx_valid <= 1'b0;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    logic err_pending;

    assign payload = prbs_in ^ {63'd0, err_pending};

    // A new request wins over consumption in the same cycle; leaving a burst drops any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pending <= 1'b0;
            err_count   <= '0;
        end else begin
            if (enter_idle) begin
                err_pending <= 1'b0;
            end else if (inject_err) begin
                err_pending <= 1'b1;
            end else if (run_active) begin
                err_pending <= 1'b0;
            end
            if (run_active && err_pending && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`else
    logic unused_inject;
    logic unused_enter_idle;

    assign payload           = prbs_in;
    assign err_count         = '0;
    assign unused_inject     = inject_err;
    assign unused_enter_idle = enter_idle;
`endif

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Scoreboard bench for prbs_test_ctrl: expected tx words are queued when bursts start, popped as tx_valid words appear.
// Expectations for error injection follow whether PRBS_ERR_INJ_EN is defined.
module tb_prbs_test_ctrl;

    localparam int unsigned PRE_LEN  = 4;
    localparam logic [63:0] PRE_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] IDLE_W   = 64'h0;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] frame_count;
    logic        inject_err;
    logic [63:0] prbs_in;
    logic        gen_en;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic [31:0] words_sent;
    logic [15:0] err_count;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];
    logic [6:0]  gen_state;
    int          n_gen;
    int          n_valid;
    int          n_done;

    prbs_test_ctrl #(
        .PREAMBLE_LEN (PRE_LEN),
        .PREAMBLE_WORD(PRE_WORD),
        .IDLE_WORD    (IDLE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .frame_count(frame_count),
        .inject_err (inject_err),
        .prbs_in    (prbs_in),
        .gen_en     (gen_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent),
        .err_count  (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PRBS-7 (x^7 + x^6 + 1), 64 serial bits per word, LSB first.
    function automatic void prbs_adv(input logic [6:0] s_in, output logic [63:0] w, output logic [6:0] s_out);
        logic [6:0] s;
        logic       b;
        s = s_in;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            b    = s[6] ^ s[5];
            w[i] = b;
            s    = {s[5:0], b};
        end
        s_out = s;
    endfunction

    task automatic push_preamble(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(PRE_WORD);
    endtask

    task automatic push_payload(input int n, input logic err_first);
        logic [6:0]  tmp;
        logic [6:0]  nxt;
        logic [63:0] w;
        tmp = gen_state;
        for (int i = 0; i < n; i++) begin
            prbs_adv(tmp, w, nxt);
            if (i == 0 && err_first) w = w ^ 64'h1;
            exp_q.push_back(w);
            tmp = nxt;
        end
    endtask

    task automatic clear_stats();
        n_gen   = 0;
        n_valid = 0;
        n_done  = 0;
    endtask

    // One clock: sample gen_en before the edge, advance the generator after it, then score tx output.
    task automatic step();
        logic        adv;
        logic [63:0] w;
        logic [63:0] exp_w;
        logic [6:0]  ns;
        @(negedge clk);
        adv = gen_en;
        @(posedge clk);
        #1;
        if (adv === 1'b1) begin
            n_gen++;
            prbs_adv(gen_state, w, ns);
            gen_state = ns;
            prbs_adv(gen_state, w, ns);
            prbs_in = w;
        end
        if (done === 1'b1) n_done++;
        checks++;
        if (tx_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h valid, expected no valid word", tx_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (tx_data !== exp_w) begin
                    errors++;
                    $display("FAIL tx_word: got %h expected %h", tx_data, exp_w);
                end
            end
        end else if (tx_data !== IDLE_W || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_idle: got data %h valid %b expected %h valid 0", tx_data, tx_valid, IDLE_W);
        end
    endtask

    task automatic pulse_start(input logic [31:0] fc);
        frame_count = fc;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (tx_data !== IDLE_W || tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            gen_en !== 1'b0 || words_sent !== 32'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL %s: got data %h valid %b done %b busy %b gen_en %b words %0d errs %0d expected all idle/zero",
                     tag, tx_data, tx_valid, done, busy, gen_en, words_sent, err_count);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_burst();
        logic seen;
        clear_stats();
        push_preamble(PRE_LEN);
        push_payload(8, 1'b0);
        pulse_start(32'd8);
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL burst_done: got no done within bound expected done");
        end
        checks++;
        if (tx_valid !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL burst_done_last_word: got valid %b remaining %0d expected valid 1 remaining 0",
                     tx_valid, exp_q.size());
        end
        checks++;
        if (words_sent !== 32'd8) begin
            errors++;
            $display("FAIL burst_words_sent: got %0d expected 8", words_sent);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL burst_after: got busy %b done %b expected 0 0", busy, done);
        end
        checks++;
        if (n_gen != 8 || n_valid != 12 || n_done != 1) begin
            errors++;
            $display("FAIL burst_counts: got gen %0d valid %0d done %0d expected 8 12 1", n_gen, n_valid, n_done);
        end
    endtask

    task automatic test_zero_frame();
        clear_stats();
        pulse_start(32'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got done %b busy %b expected 1 1", done, busy);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (n_gen != 0 || n_valid != 0 || n_done != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_counts: got gen %0d valid %0d done %0d busy %b expected 0 0 1 0",
                     n_gen, n_valid, n_done, busy);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        push_preamble(PRE_LEN);
        push_payload(2, 1'b0);
        pulse_start(32'd10);
        for (int i = 0; i < 6; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_tx_valid: got %b expected 0", tx_valid);
        end
        checks++;
        if (n_gen != 2 || n_done != 0 || words_sent !== 32'd2 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_counts: got gen %0d done %0d words %0d busy %b remaining %0d expected 2 0 2 0 0",
                     n_gen, n_done, words_sent, busy, exp_q.size());
        end
    endtask

    task automatic test_err_inject();
        logic        seen;
        logic [15:0] exp_err;
`ifdef PRBS_ERR_INJ_EN
        exp_err = 16'd1;
        push_preamble(PRE_LEN);
        push_payload(4, 1'b1);
`else
        exp_err = 16'd0;
        push_preamble(PRE_LEN);
        push_payload(4, 1'b0);
`endif
        clear_stats();
        pulse_start(32'd4);
        inject_err = 1'b1;
        step();
        inject_err = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_burst: got done %b remaining %0d expected 1 0", seen, exp_q.size());
        end
        step();
        checks++;
        if (err_count !== exp_err) begin
            errors++;
            $display("FAIL err_count: got %0d expected %0d", err_count, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic seen;
        clear_stats();
        push_preamble(PRE_LEN);
        push_payload(6, 1'b0);
        pulse_start(32'd6);
        for (int i = 0; i < 5; i++) step();
        pulse_start(32'd20);
        wait_done(seen);
        step();
        checks++;
        if (!seen || words_sent !== 32'd6 || n_valid != 10 || n_gen != 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored_start: got done %b words %0d valid %0d gen %0d busy %b expected 1 6 10 6 0",
                     seen, words_sent, n_valid, n_gen, busy);
        end
        push_preamble(2);
        pulse_start(32'd8);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_preamble");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_preamble_words: got %0d unsent expected 0", exp_q.size());
        end
        step();
        rst = 1'b0;
        clear_stats();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (busy !== 1'b0 || n_valid != 0 || n_gen != 0) begin
            errors++;
            $display("FAIL reset_release: got busy %b valid %0d gen %0d expected 0 0 0", busy, n_valid, n_gen);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        inject_err  = 1'b0;
        frame_count = '0;
        gen_state   = 7'h7F;
        begin
            logic [63:0] w0;
            logic [6:0]  s0;
            prbs_adv(gen_state, w0, s0);
            prbs_in = w0;
        end
        clear_stats();
        test_reset();
        test_burst();
        test_zero_frame();
        test_abort();
        test_err_inject();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_test_ctrl.md
PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
- REQ-001: Parameter PREAMBLE_LEN, default 4, number of preamble words sent before PRBS payload; legal range 1..255.
- REQ-002: Parameter PREAMBLE_WORD, default 64'hAAAA_AAAA_AAAA_AAAA, word sent during preamble.
- REQ-003: Parameter IDLE_WORD, default 64'h0, word driven on tx_data when not transmitting.
- REQ-004: Port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-005: Port rst, input, 1, reset, asynchronous, active-high.
- REQ-006: Port start, input, 1, single-cycle request to begin a test burst.
- REQ-007: Port abort, input, 1, terminates a burst immediately.
- REQ-008: Port frame_count, input, 32, number of PRBS payload words per burst; sampled when start is accepted.
- REQ-009: Port inject_err, input, 1, pulse requesting a single-bit error in the next payload word.
- REQ-010: Port prbs_in, input, 64, word from the 64-bit PRBS-7 generator, valid every cycle gen_en is high.
- REQ-011: Port gen_en, output, 1, advance enable for the PRBS generator.
- REQ-012: Port tx_data, output, 64, registered word to the serializer.
- REQ-013: Port tx_valid, output, 1, registered, high when tx_data carries preamble or payload.
- REQ-014: Port busy, output, 1, high in any state other than IDLE.
- REQ-015: Port done, output, 1, one-cycle pulse on normal burst completion.
- REQ-016: Port words_sent, output, 32, payload words output in the current/last burst.
- REQ-017: Port err_count, output, 16, errors injected since reset, saturating at 16'hFFFF.

Function
- REQ-018: FSM states IDLE, PREAMBLE, RUN, DONE shall be implemented.
- REQ-019: In IDLE, start=1 with abort=0 and frame_count!=0 shall latch frame_count, clear words_sent, and go to PREAMBLE.
- REQ-020: In IDLE, start=1 with frame_count==0 shall go to DONE directly; no preamble, no payload.
- REQ-021: start shall be ignored while busy=1.
- REQ-022: PREAMBLE shall last exactly PREAMBLE_LEN cycles, then go to RUN.
- REQ-023: RUN shall last exactly the latched frame_count cycles, then go to DONE; DONE lasts one cycle, then IDLE.
- REQ-024: gen_en shall be combinational, high only while state==RUN.
- REQ-025: tx_data/tx_valid shall lag state by one cycle: cycle after a PREAMBLE cycle -> PREAMBLE_WORD, valid=1; cycle after a RUN cycle -> that cycle's prbs_in (possibly corrupted), valid=1; otherwise IDLE_WORD, valid=0.
- REQ-026: done shall be high exactly during the DONE-state cycle, which coincides with the final payload word on tx_data.
- REQ-027: words_sent shall increment by 1 each RUN cycle and hold after the burst until the next accepted start.
- REQ-028: abort=1 in any non-IDLE state shall force IDLE on the next edge without a done pulse; tx_valid drops one cycle later; words_sent holds.
- REQ-029: abort shall take priority over start and over all state transitions.
- REQ-030: RUN counter shall be 32 bits; frame_count=32'hFFFF_FFFF shall complete without wrap.

Reset
- REQ-031: On rst: state IDLE, tx_data=IDLE_WORD, tx_valid=0, done=0, busy=0, gen_en=0, words_sent=0, err_count=0, pending error cleared.
- REQ-032: rst asserted mid-burst shall abandon the burst; the generator shall not be reseeded by this block.

Configuration
- REQ-033: Macro PRBS_ERR_INJ_EN defined: inject_err sets a pending flag; the next RUN-cycle word has bit 0 inverted, the flag clears, err_count increments (saturating); multiple pulses before consumption count once; pending flag clears on entry to IDLE.
- REQ-034: Macro PRBS_ERR_INJ_EN undefined: inject_err ignored, payload equals prbs_in unmodified, err_count tied to 0.

Verification
- REQ-035: Reset, then start with frame_count=8, PREAMBLE_LEN=4 -> 4 words of PREAMBLE_WORD, 8 words equal to prbs_in, done high with 8th word, words_sent=8, busy low afterwards.
- REQ-036: start with frame_count=0 -> done pulses 1 cycle after start, tx_valid never high, gen_en never high.
- REQ-037: abort on 3rd RUN cycle of a 10-word burst -> gen_en high 2 cycles, no done, words_sent=2, tx_valid low 2 cycles after abort.
- REQ-038: With PRBS_ERR_INJ_EN, inject_err during preamble -> first payload word = prbs_in ^ 64'h1, rest clean, err_count=1; without the macro, all payload clean, err_count=0.
- REQ-039: start pulsed during RUN and rst asserted mid-PREAMBLE -> second start ignored; rst returns all outputs to REQ-031 values asynchronously.
